gfsk_demodulation: RTL and testbench

BTLE RX GFSK demodulator. It is the receive-side counterpart of the TX Gaussian shaping path.
- Takes baseband I/Q at 8 samples per bit (8 Msps).
- Computes an FM discriminator bit per sample and searches all 8 sampling phases for the 32-bit access address.
- On a hit, locks to the matching phase and emits a fixed number of payload bits to the downstream dewhitening and CRC check.

---
 rtl/gfsk_demodulation.sv | 174 +++++++++++++++++
 tb/tb_gfsk_demodulation.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gfsk_demodulation.sv
// BTLE RX GFSK demodulator: FM discriminator, per-phase access-address search, locked payload output.
// Optional `GFSK_DEMODULATION_ERR_TOLERANCE_EN: accept an access address with at most one bit error.
module gfsk_demodulation #(
  parameter int SAMPLE_PER_SYMBOL       = 8,
  parameter int IQ_BIT_WIDTH            = 16,
  parameter int LEN_UNIQUE_BIT_SEQUENCE = 32,
  parameter int NUM_BIT_PAYLOAD_WIDTH   = 12
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] unique_bit_sequence,
  input  logic [NUM_BIT_PAYLOAD_WIDTH-1:0]   num_payload_bit,
  input  logic signed [IQ_BIT_WIDTH-1:0]     i,
  input  logic signed [IQ_BIT_WIDTH-1:0]     q,
  input  logic                               iq_valid,
  input  logic                               iq_valid_last,
  output logic                               hit_flag,
  output logic                               phy_bit,
  output logic                               phy_bit_valid,
  output logic                               phy_bit_valid_last
);
  localparam int W  = IQ_BIT_WIDTH;
  localparam int LW = LEN_UNIQUE_BIT_SEQUENCE;
  localparam int NW = NUM_BIT_PAYLOAD_WIDTH;
  localparam int PW = (SAMPLE_PER_SYMBOL > 1) ? $clog2(SAMPLE_PER_SYMBOL) : 1;

  // ST_SEARCH : every sample feeds its phase shift register and is matched
  // ST_LOCKED : only samples on the locked phase produce payload bits
  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  logic signed [W-1:0] r_i1, r_q1, r_ip1, r_qp1, r_i_prev, r_q_prev;
  logic [PW-1:0]       r_ph_cnt, r_p1, r_lock_ph;
  logic                r_v1, r_last1;
  logic [NW-1:0]       r_cnt;
  logic [LW-1:0]       r_sr [SAMPLE_PER_SYMBOL];
  state_t              r_state, w_state_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_i1 <= '0; r_q1 <= '0; r_ip1 <= '0; r_qp1 <= '0;
      r_i_prev <= '0; r_q_prev <= '0;
      r_ph_cnt <= '0; r_p1 <= '0;
      r_v1 <= 1'b0; r_last1 <= 1'b0;
    end else begin
      r_v1    <= iq_valid;
      r_last1 <= iq_valid & iq_valid_last;
      if (iq_valid) begin
        r_i1  <= i;
        r_q1  <= q;
        r_ip1 <= r_i_prev;
        r_qp1 <= r_q_prev;
        r_p1  <= r_ph_cnt;
        // end of capture: next sample starts a fresh phase count with zero history
        if (iq_valid_last) begin
          r_i_prev <= '0; r_q_prev <= '0; r_ph_cnt <= '0;
        end else begin
          r_i_prev <= i; r_q_prev <= q; r_ph_cnt <= r_ph_cnt + 1'b1;
        end
      end
    end
  end

  logic signed [2*W-1:0] w_ip_x, w_qp_x, w_i_x, w_q_x, w_prod_a, w_prod_b;
  logic signed [2*W:0]   w_disc;
  logic                  w_bit, w_match;
  logic [LW-1:0]         w_sr_sel, w_sr_new;

  assign w_ip_x   = {{W{r_ip1[W-1]}}, r_ip1};
  assign w_qp_x   = {{W{r_qp1[W-1]}}, r_qp1};
  assign w_i_x    = {{W{r_i1[W-1]}}, r_i1};
  assign w_q_x    = {{W{r_q1[W-1]}}, r_q1};
  assign w_prod_a = w_ip_x * w_q_x;
  assign w_prod_b = w_qp_x * w_i_x;
  assign w_disc   = {w_prod_a[2*W-1], w_prod_a} - {w_prod_b[2*W-1], w_prod_b};
  assign w_bit    = !w_disc[2*W] && (w_disc != '0);
  assign w_sr_sel = r_sr[r_p1];
  assign w_sr_new = {w_bit, w_sr_sel[LW-1:1]};

`ifdef GFSK_DEMODULATION_ERR_TOLERANCE_EN
  localparam int CW = $clog2(LW + 1);
  logic [LW-1:0] w_diff;
  logic [CW-1:0] w_pop;
  assign w_diff = w_sr_new ^ unique_bit_sequence;
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < LW; k++) w_pop = w_pop + CW'(w_diff[k]);
  end
  assign w_match = (w_pop <= CW'(1));
`else
  assign w_match = (w_sr_new == unique_bit_sequence);
`endif

  logic w_hit_nxt, w_bv_nxt, w_bit_nxt, w_last_nxt;
  logic w_sr_shift, w_sr_clr, w_load, w_dec;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_SEARCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = 1'b0;
    w_bv_nxt    = 1'b0;
    w_bit_nxt   = 1'b0;
    w_last_nxt  = 1'b0;
    w_sr_shift  = 1'b0;
    w_sr_clr    = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    if (r_v1) begin
      case (r_state)
        ST_SEARCH: begin
          w_sr_shift = 1'b1;
          if (w_match) begin
            w_hit_nxt = 1'b1;
            // zero-length packet: clearing stops neighbouring phases re-hitting on the same AA
            if (num_payload_bit == '0) w_sr_clr = 1'b1;
            else begin
              w_load      = 1'b1;
              w_state_nxt = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (r_p1 == r_lock_ph) begin
            w_bv_nxt  = 1'b1;
            w_bit_nxt = w_bit;
            w_dec     = 1'b1;
            if (r_cnt == NW'(1)) begin
              w_last_nxt  = 1'b1;
              w_sr_clr    = 1'b1;
              w_state_nxt = ST_SEARCH;
            end
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
      // capture end aborts an unfinished packet; a completed one keeps its last flag
      if (r_last1) begin
        w_sr_clr    = 1'b1;
        w_state_nxt = ST_SEARCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lock_ph <= '0;
      r_cnt     <= '0;
      for (int k = 0; k < SAMPLE_PER_SYMBOL; k++) r_sr[k] <= '0;
      hit_flag           <= 1'b0;
      phy_bit            <= 1'b0;
      phy_bit_valid      <= 1'b0;
      phy_bit_valid_last <= 1'b0;
    end else begin
      if (w_load) begin
        r_lock_ph <= r_p1;
        r_cnt     <= num_payload_bit;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_sr_clr) begin
        for (int k = 0; k < SAMPLE_PER_SYMBOL; k++) r_sr[k] <= '0;
      end else if (w_sr_shift) begin
        r_sr[r_p1] <= w_sr_new;
      end
      hit_flag           <= w_hit_nxt;
      phy_bit            <= w_bit_nxt;
      phy_bit_valid      <= w_bv_nxt;
      phy_bit_valid_last <= w_last_nxt;
    end
  end
endmodule

// File: tb/tb_gfsk_demodulation.sv
`timescale 1ns/1ps
// Directed bench for gfsk_demodulation: ideal FSK phasor stimulus, expected hits/bits queued per sample.
module tb_gfsk_demodulation;
  localparam logic [31:0] AA = 32'h8E89BED6;
  localparam logic [63:0] P1 = 64'h5A3C_96F0_1E2D_C3B4;
  localparam logic [63:0] P2 = 64'hC0FF_EE12_9B7D_4A61;

  logic               clk = 1'b0;
  logic               rstn;
  logic [31:0]        unique_bit_sequence;
  logic [11:0]        num_payload_bit;
  logic signed [15:0] i, q;
  logic               iq_valid, iq_valid_last;
  logic               hit_flag, phy_bit, phy_bit_valid, phy_bit_valid_last;

  typedef struct {
    logic hit;
    logic bv;
    logic b;
    logic last;
    int   due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cos_tab [16] = '{10000, 9239, 7071, 3827, 0, -3827, -7071, -9239,
                       -10000, -9239, -7071, -3827, 0, 3827, 7071, 9239};

  gfsk_demodulation dut (
    .clk                 (clk),
    .rstn                (rstn),
    .unique_bit_sequence (unique_bit_sequence),
    .num_payload_bit     (num_payload_bit),
    .i                   (i),
    .q                   (q),
    .iq_valid            (iq_valid),
    .iq_valid_last       (iq_valid_last),
    .hit_flag            (hit_flag),
    .phy_bit             (phy_bit),
    .phy_bit_valid       (phy_bit_valid),
    .phy_bit_valid_last  (phy_bit_valid_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : monitor
    exp_t e;
    logic [3:0] obs, expv;
    #1;
    cyc++;
    if (hit_flag || phy_bit_valid || phy_bit_valid_last) begin
      obs = {hit_flag, phy_bit_valid, phy_bit_valid & phy_bit, phy_bit_valid_last};
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_output cycle=%0d observed hit/valid/bit/last=%b required none", cyc, obs);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        expv = {e.hit, e.bv, e.b, e.last};
        checks++;
        assert (obs === expv) else begin
          errors++;
          $error("FAIL out_event cycle=%0d observed=%b expected=%b", cyc, obs, expv);
        end
        checks++;
        assert (cyc === e.due) else begin
          errors++;
          $error("FAIL latency observed_cycle=%0d expected_cycle=%0d", cyc, e.due);
        end
      end
    end
  end

  task automatic push_exp(input logic h, input logic bv, input logic b, input logic l);
    exp_t e;
    e.hit = h; e.bv = bv; e.b = b; e.last = l; e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic drive(input int ang, input bit last);
    @(negedge clk);
    i = 16'(cos_tab[ang & 15]);
    q = 16'(cos_tab[(ang + 12) & 15]);
    iq_valid = 1'b1;
    iq_valid_last = last;
  endtask

  task automatic idle();
    @(negedge clk);
    iq_valid = 1'b0;
    iq_valid_last = 1'b0;
  endtask

  // offset samples of unrotated carrier, then 8 samples per symbol: AA bits (bit 0 first) then payload
  task automatic send_capture(input logic [31:0] aa, input logic [63:0] pay, input int offset,
                              input int nsamp, input bit use_last, input bit exp_hit,
                              input int nbits, input bit gaps);
    int ang;
    int h;
    int sym;
    int k;
    logic b;
    ang = 0;
    h = offset + 8 * 31;
    for (int s = 0; s < nsamp; s++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) idle();
      if (s >= offset) begin
        sym = (s - offset) / 8;
        b = (sym < 32) ? aa[sym] : pay[sym - 32];
        ang = b ? ang + 1 : ang - 1;
      end
      drive(ang, use_last && (s == nsamp - 1));
      if (exp_hit && s == h) push_exp(1'b1, 1'b0, 1'b0, 1'b0);
      if (exp_hit && s > h && ((s - h) % 8) == 0) begin
        k = (s - h) / 8 - 1;
        if (k < nbits) push_exp(1'b0, 1'b1, pay[k], k == nbits - 1);
      end
    end
  endtask

  task automatic drain(input string tag);
    idle();
    repeat (4) @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s pending_outputs=%0d required=0", tag, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    bit tol_hit;
    rstn = 1'b0;
    i = '0; q = '0;
    iq_valid = 1'b0; iq_valid_last = 1'b0;
    unique_bit_sequence = AA;
    num_payload_bit = 12'd40;
    repeat (3) @(negedge clk);
    checks++; assert (hit_flag === 1'b0) else begin errors++; $error("FAIL rst_hit observed=%b expected=0", hit_flag); end
    checks++; assert (phy_bit === 1'b0) else begin errors++; $error("FAIL rst_bit observed=%b expected=0", phy_bit); end
    checks++; assert (phy_bit_valid === 1'b0) else begin errors++; $error("FAIL rst_valid observed=%b expected=0", phy_bit_valid); end
    checks++; assert (phy_bit_valid_last === 1'b0) else begin errors++; $error("FAIL rst_last observed=%b expected=0", phy_bit_valid_last); end
    @(negedge clk); rstn = 1'b1;
    idle(); idle();

    // phase 0, 40 payload bits
    send_capture(AA, P1, 0, 576, 1'b1, 1'b1, 40, 1'b0);
    drain("t1_phase0");

    // 3-sample delay locks phase 3; random idle gaps exercise the hold behaviour
    send_capture(AA, P1, 3, 579, 1'b1, 1'b1, 40, 1'b1);
    drain("t2_phase3");

    // single bit error in the access address
`ifdef GFSK_DEMODULATION_ERR_TOLERANCE_EN
    tol_hit = 1'b1;
`else
    tol_hit = 1'b0;
`endif
    send_capture(AA ^ 32'h0000_0020, P2, 0, 576, 1'b1, tol_hit, 40, 1'b0);
    drain("t3_bit_error");

    // capture ends after 20 payload bits: no last flag, then a clean packet
    send_capture(AA, P2, 0, 411, 1'b1, 1'b1, 40, 1'b0);
    drain("t4_abort");
    send_capture(AA, P1, 0, 576, 1'b1, 1'b1, 40, 1'b0);
    drain("t4_recover");

    // reset pulse right after the 10th payload bit is on the outputs
    send_capture(AA, P1, 0, 330, 1'b0, 1'b1, 40, 1'b0);
    @(negedge clk);
    iq_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; assert (hit_flag === 1'b0) else begin errors++; $error("FAIL t5_rst_hit observed=%b expected=0", hit_flag); end
    checks++; assert (phy_bit === 1'b0) else begin errors++; $error("FAIL t5_rst_bit observed=%b expected=0", phy_bit); end
    checks++; assert (phy_bit_valid === 1'b0) else begin errors++; $error("FAIL t5_rst_valid observed=%b expected=0", phy_bit_valid); end
    checks++; assert (phy_bit_valid_last === 1'b0) else begin errors++; $error("FAIL t5_rst_last observed=%b expected=0", phy_bit_valid_last); end
    sb.delete();
    @(negedge clk); rstn = 1'b1;
    repeat (4) idle();
    send_capture(AA, P2, 5, 581, 1'b1, 1'b1, 40, 1'b0);
    drain("t5_after_reset");

    // zero-length packet, then an 8-bit packet
    num_payload_bit = 12'd0;
    send_capture(AA, P1, 0, 384, 1'b1, 1'b1, 0, 1'b0);
    drain("t6_zero_len");
    num_payload_bit = 12'd8;
    send_capture(AA, P2, 0, 336, 1'b1, 1'b1, 8, 1'b0);
    drain("t6_eight_bits");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
